fwrisc_decode_alu: RTL
======================

Name: fwrisc_decode_alu

Overview:
Decode-and-operand-fetch stage directly upstream of the FWRISC ALU. It accepts one 32-bit RV32I instruction with its PC and reads rs1/rs2 from the synchronous-read register file. It then decodes the ALU-class instructions (OP, OP-IMM, LUI, AUIPC) and presents registered op_a/op_b/op/rd to the ALU side through a valid/ready handshake. All other encodings are flagged illegal, not dropped.

Parameters:
ZERO_X0, 1, when 1 the operand for register index 0 is forced to 32'h0 regardless of the register-file read data.

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-low; sampled at the rising edge of clock
instr_valid  input  1  upstream instruction available
instr_ready  output  1  stage can accept an instruction
instr  input  32  instruction word
instr_pc  input  32  PC of instr
ra_raddr  output  5  regfile read address A (rs1)
rb_raddr  output  5  regfile read address B (rs2)
ra_rdata  input  32  regfile data A, valid the cycle after the address is sampled
rb_rdata  input  32  regfile data B, same timing as ra_rdata
alu_valid  output  1  op_a/op_b/op/rd/illegal valid
alu_ready  input  1  ALU side consumes
op_a  output  32  ALU operand A
op_b  output  32  ALU operand B
op  output  5  ALU opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4
rd  output  5  destination register index
illegal  output  1  instruction is not a supported ALU op

Behaviour:
- FSM states: IDLE, RD, LATCH, OUT.
- Reset (reset==0 at edge), from any state:
  - state goes to IDLE.
  - alu_valid=0, op_a=0, op_b=0, op=0, rd=0, illegal=0.
  - Captured instr and pc are cleared to 0.
  - instr_ready=1 from the following cycle.
  - A transaction in flight is discarded with no output.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge k: capture instr and instr_pc, go to RD.
- RD:
  - ra_raddr=instr[19:15] and rb_raddr=instr[24:20] of the captured word.
  - At edge k+1 the regfile samples the addresses; go to LATCH.
- LATCH:
  - ra_rdata/rb_rdata are valid.
  - At edge k+2, register op_a, op_b, op, rd and illegal; go to OUT.
- OUT:
  - alu_valid=1; all outputs stay stable until the handshake.
  - On alu_valid&&alu_ready at an edge: alu_valid drops and the FSM returns to IDLE.
- Timing: minimum latency is accept edge k to alu_valid high after edge k+2. Throughput is one instruction per 4 cycles when alu_ready is held 1.
- instr_ready=0 in RD, LATCH and OUT; instr_valid is ignored there.
- ra_raddr/rb_raddr hold the captured fields in every state (0 after reset).
- Decode, from the captured instr (opcode = instr[6:0]):
  - 0110011, R-type:
    - op_a=rs1 data, op_b=rs2 data.
    - funct3 000 with funct7 0000000 gives ADD; with funct7 0100000 gives SUB.
    - funct3 100 gives XOR, 110 gives OR, 111 gives AND; each requires funct7 0000000.
  - 0010011, I-type:
    - op_a=rs1 data, op_b=sign-extended instr[31:20].
    - funct3 000 gives ADD, 100 gives XOR, 110 gives OR, 111 gives AND.
  - 0110111, LUI: op_a=0, op_b={instr[31:12],12'h000}, op=ADD.
  - 0010111, AUIPC: op_a=captured pc, op_b={instr[31:12],12'h000}, op=ADD.
  - rd=instr[11:7] for all legal ops.
  - Any other opcode/funct3/funct7 combination (shifts, SLT, loads, branches, etc.): illegal=1, op=ADD, op_a=0, op_b=0, rd=0. It is still presented with alu_valid=1.
- x0 handling: with ZERO_X0=1, a source index of 0 yields operand 0 even if rdata is nonzero.
- Widths: immediates extend to 32 bits; no overflow detection; the PC is passed unmodified.
- Simultaneous reset and handshake: reset wins and no transfer is recorded.

Test Plan:
- x1=5, x2=7; instr 0x002081B3 (ADD x3,x1,x2), alu_ready=1 -> alu_valid 2 edges after accept; op_a=5, op_b=7, op=0, rd=3, illegal=0; instr_ready back to 1 the cycle after the handshake.
- instr 0x402081B3 (SUB) -> op=1, rd=3. Then 0xFFF00293 (ADDI x5,x0,-1) with regfile A returning 0xDEADBEEF -> op_a=0, op_b=0xFFFFFFFF, op=0, rd=5.
- 0x123450B7 (LUI x1,0x12345) -> op_a=0, op_b=0x12345000, rd=1. Then 0x00001117 (AUIPC x2,1) with pc=0x80000000 -> op_a=0x80000000, op_b=0x00001000, rd=2.
- 0x002091B3 (SLL, unsupported) -> illegal=1, op=0, op_a=0, op_b=0, rd=0, alu_valid=1.
- Backpressure: alu_ready=0 for 5 cycles in OUT -> all outputs stable, instr_ready=0, a new instr_valid is not accepted. alu_ready=1 -> single transfer, then IDLE.
- Reset driven 0 for one edge while in RD, and again while in OUT -> alu_valid=0 and all outputs 0 next cycle, instr_ready=1. The aborted instruction never appears on the ALU side.

Source files
------------

// File: rtl/fwrisc_decode_alu.sv
// fwrisc_decode_alu
//   Decode and operand-fetch stage in front of the FWRISC ALU. It takes one
//   RV32I word with its PC and reads rs1/rs2 from a synchronous-read register
//   file. It then presents registered ALU operands, opcode and rd through a
//   valid/ready pair. Non-ALU encodings are passed down flagged as illegal.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   instr_valid/ready       upstream handshake; instr, instr_pc payload
//   ra_raddr, rb_raddr      regfile read addresses (rs1, rs2 of captured word)
//   ra_rdata, rb_rdata      regfile data, one cycle after address sampling
//   alu_valid/ready         downstream handshake
//   op_a, op_b, op, rd      ALU operands, opcode (ADD0 SUB1 AND2 OR3 XOR4), dest
//   illegal                 word is not a supported ALU instruction
module fwrisc_decode_alu #(
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  output logic [4:0]  ra_raddr,
  output logic [4:0]  rb_raddr,
  input  logic [31:0] ra_rdata,
  input  logic [31:0] rb_rdata,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  op,
  output logic [4:0]  rd,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, RD, LATCH, OUT} state_t;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  state_t      state;
  logic [31:0] cap_instr;
  logic [31:0] cap_pc;

  // Read addresses come straight from the captured word, so they are stable
  // through RD/LATCH and read 0 after reset.
  assign ra_raddr    = cap_instr[19:15];
  assign rb_raddr    = cap_instr[24:20];
  assign instr_ready = (state == IDLE);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_u;

  assign opcode = cap_instr[6:0];
  assign funct3 = cap_instr[14:12];
  assign funct7 = cap_instr[31:25];
  assign imm_i  = {{20{cap_instr[31]}}, cap_instr[31:20]};
  assign imm_u  = {cap_instr[31:12], 12'h000};
  assign rs1_val = (ZERO_X0 && ra_raddr == 5'd0) ? 32'h0 : ra_rdata;
  assign rs2_val = (ZERO_X0 && rb_raddr == 5'd0) ? 32'h0 : rb_rdata;

  logic        ok;
  logic [4:0]  c_op;
  logic [31:0] c_a, c_b;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_op, dec_rd;
  logic        dec_ill;

  always_comb begin
    ok   = 1'b0;
    c_op = OP_ADD;
    c_a  = rs1_val;
    c_b  = rs2_val;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin ok = 1'b1; c_op = OP_ADD; end
            else if (funct7 == 7'b0100000) begin ok = 1'b1; c_op = OP_SUB; end
          end
          3'b100: begin ok = (funct7 == 7'b0000000); c_op = OP_XOR; end
          3'b110: begin ok = (funct7 == 7'b0000000); c_op = OP_OR;  end
          3'b111: begin ok = (funct7 == 7'b0000000); c_op = OP_AND; end
          default: ok = 1'b0;
        endcase
      end
      OPC_IMM: begin
        c_b = imm_i;
        case (funct3)
          3'b000: begin ok = 1'b1; c_op = OP_ADD; end
          3'b100: begin ok = 1'b1; c_op = OP_XOR; end
          3'b110: begin ok = 1'b1; c_op = OP_OR;  end
          3'b111: begin ok = 1'b1; c_op = OP_AND; end
          default: ok = 1'b0;
        endcase
      end
      OPC_LUI:   begin ok = 1'b1; c_a = 32'h0;  c_b = imm_u; end
      OPC_AUIPC: begin ok = 1'b1; c_a = cap_pc; c_b = imm_u; end
      default:   ok = 1'b0;
    endcase

    // Illegal words still go downstream, but with a neutral payload.
    dec_ill = ~ok;
    dec_op  = ok ? c_op : OP_ADD;
    dec_a   = ok ? c_a : 32'h0;
    dec_b   = ok ? c_b : 32'h0;
    dec_rd  = ok ? cap_instr[11:7] : 5'd0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cap_instr <= 32'h0;
      cap_pc    <= 32'h0;
      alu_valid <= 1'b0;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      op        <= 5'd0;
      rd        <= 5'd0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            cap_instr <= instr;
            cap_pc    <= instr_pc;
            state     <= RD;
          end
        end
        RD: state <= LATCH;  // regfile samples the addresses on this edge
        LATCH: begin
          op_a      <= dec_a;
          op_b      <= dec_b;
          op        <= dec_op;
          rd        <= dec_rd;
          illegal   <= dec_ill;
          alu_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (alu_ready) begin
            alu_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
